// File: rtl/vp_status_responder.sv
// Memory-mapped virtual-peripheral responder on the data OBI port: end-of-test
// flags, console print FIFO and a free-running 64-bit cycle counter.
module vp_status_responder #(
  parameter logic [31:0] BASE_ADDR        = 32'h1500_0000,
  parameter int unsigned PRINT_FIFO_DEPTH = 4,
  parameter logic [31:0] PASS_MAGIC       = 32'd123456789,
  parameter logic [31:0] FAIL_MAGIC       = 32'd1
) (
  input  logic        core_clk,
  input  logic        core_rst_n,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        tests_passed_o,
  output logic        tests_failed_o,
  output logic        exit_valid_o,
  output logic [31:0] exit_value_o,
  output logic        print_valid_o,
  output logic [7:0]  print_char_o,
  input  logic        print_ready_i
);

  localparam int unsigned AW = $clog2(PRINT_FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_LEVEL = CW'(PRINT_FIFO_DEPTH);

  typedef enum logic [2:0] {
    REG_PRINT       = 3'd0,
    REG_TEST_STATUS = 3'd1,
    REG_EXIT        = 3'd2,
    REG_CYCLE_LO    = 3'd3,
    REG_CYCLE_HI    = 3'd4,
    REG_PRINT_LEVEL = 3'd5,
    REG_RSVD6       = 3'd6,
    REG_RSVD7       = 3'd7
  } reg_sel_e;

  reg_sel_e      reg_sel;
  logic          fifo_empty;
  logic          fifo_full;
  logic          print_wr;
  logic          push;
  logic          pop;
  logic          gnt;
  logic [31:0]   rd_data;

  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] level_q;
  logic [7:0]    fifo_mem [PRINT_FIFO_DEPTH];

  logic [63:0]   cycle_cnt_q;
  logic [31:0]   cycle_hi_shadow_q;
  logic          rvalid_q;
  logic [31:0]   rdata_q;
  logic          passed_q;
  logic          failed_q;
  logic          exit_valid_q;
  logic [31:0]   exit_value_q;

  // The wrapper decodes the window; only the register offset is used here.
  logic unused_bits;
  assign unused_bits = ^{addr_i[31:5], addr_i[1:0], be_i[3:1], BASE_ADDR};

  assign reg_sel    = reg_sel_e'(addr_i[4:2]);
  assign fifo_empty = (level_q == '0);
  assign fifo_full  = (level_q == FULL_LEVEL);
  assign pop        = !fifo_empty && print_ready_i;
  assign print_wr   = req_i && we_i && (reg_sel == REG_PRINT) && be_i[0];
  // A simultaneous pop frees the slot, so a full FIFO only stalls without one.
  assign gnt        = req_i && !(print_wr && fifo_full && !pop);
  assign push       = gnt && print_wr;

  always_comb begin
    rd_data = '0;
    if (!we_i) begin
      case (reg_sel)
        REG_CYCLE_LO:    rd_data = cycle_cnt_q[31:0];
        REG_CYCLE_HI:    rd_data = cycle_hi_shadow_q;
        REG_PRINT_LEVEL: rd_data = 32'(level_q);
        default:         rd_data = '0;
      endcase
    end
  end

  always_ff @(posedge core_clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      cycle_cnt_q       <= '0;
      cycle_hi_shadow_q <= '0;
      rvalid_q          <= 1'b0;
      rdata_q           <= '0;
      passed_q          <= 1'b0;
      failed_q          <= 1'b0;
      exit_valid_q      <= 1'b0;
      exit_value_q      <= '0;
    end else begin
      cycle_cnt_q  <= cycle_cnt_q + 64'd1;
      rvalid_q     <= gnt;
      rdata_q      <= gnt ? rd_data : '0;
      passed_q     <= gnt && we_i && (reg_sel == REG_TEST_STATUS) && (wdata_i == PASS_MAGIC);
      failed_q     <= gnt && we_i && (reg_sel == REG_TEST_STATUS) && (wdata_i == FAIL_MAGIC);
      exit_valid_q <= gnt && we_i && (reg_sel == REG_EXIT);
      if (gnt && we_i && (reg_sel == REG_EXIT)) begin
        exit_value_q <= wdata_i;
      end
      // HI reads return the upper word captured by the preceding LO read.
      if (gnt && !we_i && (reg_sel == REG_CYCLE_LO)) begin
        cycle_hi_shadow_q <= cycle_cnt_q[63:32];
      end
    end
  end

  always_ff @(posedge core_clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({push, pop})
        2'b10:   level_q <= level_q + CW'(1);
        2'b01:   level_q <= level_q - CW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge core_clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= wdata_i[7:0];
    end
  end

  assign gnt_o          = gnt;
  assign rvalid_o       = rvalid_q;
  assign rdata_o        = rdata_q;
  assign tests_passed_o = passed_q;
  assign tests_failed_o = failed_q;
  assign exit_valid_o   = exit_valid_q;
  assign exit_value_o   = exit_value_q;
  assign print_valid_o  = !fifo_empty;
  assign print_char_o   = fifo_empty ? '0 : fifo_mem[rd_ptr_q];

endmodule

// File: tb/tb_vp_status_responder.sv
// Randomized scoreboard bench for vp_status_responder: a queue-based reference
// model predicts grants and responses, a monitor pops and compares on rvalid.
module tb_vp_status_responder;

  localparam logic [31:0] BASE       = 32'h1500_0000;
  localparam int unsigned DEPTH      = 4;
  localparam logic [31:0] PASS_MAGIC = 32'd123456789;
  localparam logic [31:0] FAIL_MAGIC = 32'd1;

  logic        core_clk = 1'b0;
  logic        core_rst_n = 1'b0;
  logic        req_i = 1'b0;
  logic        we_i = 1'b0;
  logic [3:0]  be_i = '0;
  logic [31:0] addr_i = '0;
  logic [31:0] wdata_i = '0;
  logic        gnt_o;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic        tests_passed_o;
  logic        tests_failed_o;
  logic        exit_valid_o;
  logic [31:0] exit_value_o;
  logic        print_valid_o;
  logic [7:0]  print_char_o;
  logic        print_ready_i = 1'b0;

  vp_status_responder #(
    .BASE_ADDR(BASE),
    .PRINT_FIFO_DEPTH(DEPTH),
    .PASS_MAGIC(PASS_MAGIC),
    .FAIL_MAGIC(FAIL_MAGIC)
  ) dut (
    .core_clk(core_clk),
    .core_rst_n(core_rst_n),
    .req_i(req_i),
    .we_i(we_i),
    .be_i(be_i),
    .addr_i(addr_i),
    .wdata_i(wdata_i),
    .gnt_o(gnt_o),
    .rvalid_o(rvalid_o),
    .rdata_o(rdata_o),
    .tests_passed_o(tests_passed_o),
    .tests_failed_o(tests_failed_o),
    .exit_valid_o(exit_valid_o),
    .exit_value_o(exit_value_o),
    .print_valid_o(print_valid_o),
    .print_char_o(print_char_o),
    .print_ready_i(print_ready_i)
  );

  always #5 core_clk = ~core_clk;

  typedef struct packed {
    logic [31:0] rdata;
    logic        passed;
    logic        failed;
    logic        exitv;
    int unsigned due;
  } rsp_t;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;
  logic [63:0] mc = '0;
  logic [31:0] m_shadow = '0;
  logic [31:0] m_exit = '0;
  logic [7:0]  pq[$];
  logic [7:0]  sink[$];
  rsp_t        sb[$];
  bit          ready_rand = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge core_clk) cyc++;

  // Reference cycle count: number of clock edges since reset release.
  always @(posedge core_clk or negedge core_rst_n) begin
    if (!core_rst_n) mc = '0;
    else mc = mc + 64'd1;
  end

  always @(posedge core_clk) begin
    if (ready_rand) begin
      #1 print_ready_i = 1'($urandom_range(0, 1));
    end
  end

  // Reference model: evaluated mid-cycle with stable inputs, predicts the edge.
  always @(negedge core_clk) begin : model
    logic [2:0] off;
    logic       pop;
    logic       wants_push;
    logic       g;
    rsp_t       r;
    if (!core_rst_n) begin
      pq.delete();
      m_exit   = '0;
      m_shadow = '0;
      check("rst_print_valid", 64'(print_valid_o), 64'd0);
      check("rst_print_char", 64'(print_char_o), 64'd0);
      check("rst_exit_value", 64'(exit_value_o), 64'd0);
    end else begin
      check("print_valid", 64'(print_valid_o), 64'(pq.size() != 0));
      check("print_char", 64'(print_char_o), (pq.size() != 0) ? 64'(pq[0]) : 64'd0);
      check("exit_value", 64'(exit_value_o), 64'(m_exit));
      off        = addr_i[4:2];
      pop        = (pq.size() != 0) && print_ready_i;
      wants_push = req_i && we_i && (off == 3'd0) && be_i[0];
      g          = req_i && !(wants_push && (pq.size() == DEPTH) && !pop);
      check("gnt", 64'(gnt_o), 64'(g));
      if (g) begin
        r        = '0;
        r.due    = cyc + 1;
        r.passed = we_i && (off == 3'd1) && (wdata_i == PASS_MAGIC);
        r.failed = we_i && (off == 3'd1) && (wdata_i == FAIL_MAGIC);
        r.exitv  = we_i && (off == 3'd2);
        if (!we_i) begin
          if (off == 3'd3) r.rdata = mc[31:0];
          else if (off == 3'd4) r.rdata = m_shadow;
          else if (off == 3'd5) r.rdata = 32'(pq.size());
        end
        sb.push_back(r);
        if (!we_i && off == 3'd3) m_shadow = mc[63:32];
        if (r.exitv) m_exit = wdata_i;
      end
      if (pop) begin
        sink.push_back(print_char_o);
        void'(pq.pop_front());
      end
      if (g && wants_push) pq.push_back(wdata_i[7:0]);
    end
  end

  always @(negedge core_clk) begin : monitor
    rsp_t e;
    if (!core_rst_n) begin
      sb.delete();
      check("rst_rvalid", 64'(rvalid_o), 64'd0);
    end else if (rvalid_o) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_rvalid: got rvalid=1 expected no response at %0t", $time);
      end else begin
        e = sb.pop_front();
        check("rsp_cycle", 64'(cyc), 64'(e.due));
        check("rdata", 64'(rdata_o), 64'(e.rdata));
        check("tests_passed", 64'(tests_passed_o), 64'(e.passed));
        check("tests_failed", 64'(tests_failed_o), 64'(e.failed));
        check("exit_valid", 64'(exit_valid_o), 64'(e.exitv));
      end
    end else begin
      check("idle_outputs", {31'd0, rdata_o, tests_passed_o, tests_failed_o, exit_valid_o}, 64'd0);
      if (sb.size() != 0 && sb[0].due <= cyc) begin
        checks++;
        errors++;
        $display("FAIL missing_rvalid: got rvalid=0 expected 1 at %0t", $time);
        void'(sb.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge core_clk);
    #1;
  endtask

  task automatic do_access(input logic w, input logic [2:0] off, input logic [31:0] d,
                           input logic [3:0] be);
    bit          g;
    int unsigned n;
    req_i   = 1'b1;
    we_i    = w;
    addr_i  = BASE | {27'd0, off, 2'b00};
    wdata_i = d;
    be_i    = be;
    n = 0;
    do begin
      @(negedge core_clk);
      g = gnt_o;
      step();
      n++;
    end while (!g && n < 100);
    if (!g) begin
      checks++;
      errors++;
      $display("FAIL grant_timeout: got gnt=0 for 100 cycles expected 1 at %0t", $time);
    end
    req_i   = 1'b0;
    we_i    = 1'b0;
    wdata_i = '0;
    be_i    = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion expected finish at %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [2:0]  off;
    logic        w;
    logic [31:0] d;
    logic [3:0]  be;
    logic [7:0]  exp_chars[$];

    repeat (3) step();
    core_rst_n = 1'b1;
    step();

    do_access(1'b1, 3'd1, PASS_MAGIC, 4'hF);
    do_access(1'b1, 3'd1, FAIL_MAGIC, 4'hF);
    do_access(1'b1, 3'd1, 32'd7, 4'hF);
    do_access(1'b1, 3'd2, 32'h2A, 4'h1);
    repeat (3) step();
    do_access(1'b1, 3'd2, 32'h0, 4'hF);

    // Fill the FIFO with the sink stalled, then release it while E waits.
    print_ready_i = 1'b0;
    sink.delete();
    for (int unsigned i = 0; i < 4; i++) do_access(1'b1, 3'd0, 32'h41 + i, 4'hF);
    do_access(1'b0, 3'd5, 32'h0, 4'hF);
    fork
      do_access(1'b1, 3'd0, 32'h45, 4'h1);
      begin
        repeat (4) step();
        print_ready_i = 1'b1;
      end
    join
    repeat (8) step();
    exp_chars = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45};
    check("sink_count", 64'(sink.size()), 64'd5);
    for (int unsigned i = 0; i < 5 && i < sink.size(); i++) check("sink_char", 64'(sink[i]), 64'(exp_chars[i]));

    // Coherent 64-bit read across the low-word carry.
    force dut.cycle_cnt_q = 64'h0000_0001_FFFF_FFFD;
    mc = 64'h0000_0001_FFFF_FFFD;
    @(negedge core_clk);
    release dut.cycle_cnt_q;
    step();
    do_access(1'b0, 3'd3, 32'h0, 4'hF);
    do_access(1'b0, 3'd4, 32'h0, 4'hF);
    check("shadow_hi", 64'(m_shadow), 64'd1);
    do_access(1'b0, 3'd3, 32'h0, 4'hF);
    do_access(1'b0, 3'd4, 32'h0, 4'hF);

    // Reset in the cycle after a granted read drops its response.
    print_ready_i = 1'b0;
    do_access(1'b1, 3'd0, 32'h58, 4'hF);
    do_access(1'b1, 3'd0, 32'h59, 4'hF);
    do_access(1'b0, 3'd5, 32'h0, 4'hF);
    core_rst_n = 1'b0;
    repeat (3) step();
    core_rst_n = 1'b1;
    print_ready_i = 1'b1;
    step();
    do_access(1'b0, 3'd3, 32'h0, 4'hF);
    do_access(1'b0, 3'd5, 32'h0, 4'hF);

    ready_rand = 1'b1;
    for (int unsigned i = 0; i < 300; i++) begin
      off = 3'($urandom_range(0, 7));
      w   = 1'($urandom_range(0, 1));
      d   = $urandom;
      case ($urandom_range(0, 3))
        0: if (off == 3'd1) d = PASS_MAGIC;
        1: if (off == 3'd1) d = FAIL_MAGIC;
        default: ;
      endcase
      be = 4'($urandom_range(0, 15));
      if (off == 3'd0) be[0] = 1'b1;
      do_access(w, off, d, be);
      repeat ($urandom_range(0, 2)) step();
    end
    ready_rand = 1'b0;
    step();
    print_ready_i = 1'b1;
    repeat (20) step();
    check("sb_drained", 64'(sb.size()), 64'd0);
    check("fifo_drained", 64'(print_valid_o), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
